// File: rtl/fptd_trellis_pkg.sv
// Shared constants and helpers for the 8-state LTE RSC trellis used by the
// alpha and beta state-metric stages of the parallel turbo decoder.
package fptd_trellis_pkg;

   localparam int NUM_STATES = 8;

   // Indexed [state][b1]; state = 4*r1 + 2*r2 + r3
   localparam logic [2:0] NEXT_STATE [NUM_STATES][2] = '{
      '{3'd0, 3'd4}, '{3'd4, 3'd0}, '{3'd5, 3'd1}, '{3'd1, 3'd5},
      '{3'd2, 3'd6}, '{3'd6, 3'd2}, '{3'd7, 3'd3}, '{3'd3, 3'd7}
   };

   // Parity bit b2 emitted on each transition, indexed [state][b1]
   localparam logic PARITY [NUM_STATES][2] = '{
      '{1'b0, 1'b1}, '{1'b0, 1'b1}, '{1'b1, 1'b0}, '{1'b1, 1'b0},
      '{1'b1, 1'b0}, '{1'b1, 1'b0}, '{1'b0, 1'b1}, '{1'b0, 1'b1}
   };

   // Start vector: state 0 favoured, all others at -2^(k-2)
   function automatic logic [NUM_STATES-1:0][31:0] alpha_init(input int k);
      logic [NUM_STATES-1:0][31:0] v;
      v[0] = '0;
      for (int s = 1; s < NUM_STATES; s++) v[s] = -(32'sd1 <<< (k - 2));
      return v;
   endfunction

   // Clip a sign-extended value into the signed range of w_out bits
   function automatic logic signed [31:0] saturate(input logic signed [31:0] x,
                                                   input int w_out);
      logic signed [31:0] hi;
      logic signed [31:0] lo;
      hi = (32'sd1 <<< (w_out - 1)) - 32'sd1;
      lo = -(32'sd1 <<< (w_out - 1));
      if (x > hi) return hi;
      if (x < lo) return lo;
      return x;
   endfunction

endpackage

// File: rtl/alpha_pipe_razor1_acs.sv
// Two-way add-compare-select for a single next state of the trellis.
module acs_unit #(
   parameter int K = 8
) (
   input  logic signed [K-1:0] i_alpha0,
   input  logic signed [K:0]   i_gamma0,
   input  logic signed [K-1:0] i_alpha1,
   input  logic signed [K:0]   i_gamma1,
   output logic signed [K:0]   o_metric
);

   logic signed [K:0] w_sum0;
   logic signed [K:0] w_sum1;

   assign w_sum0 = (K+1)'(i_alpha0) + i_gamma0;
   assign w_sum1 = (K+1)'(i_alpha1) + i_gamma1;

   // Strict compare: on a tie the b1=0 branch is kept
   assign o_metric = (w_sum1 > w_sum0) ? w_sum1 : w_sum0;

endmodule

// File: rtl/alpha_pipe_razor1.sv
// Forward alpha stage for one trellis index: ACS over 8 states, normalise to
// state 0, saturate and register, with razor error pass-through and Iter count.
module alpha_pipe_razor1
   import fptd_trellis_pkg::*;
#(
   parameter int N     = 5,
   parameter int M     = 6,
   parameter int K     = 8,
   parameter int I_MAX = 8
) (
   input  logic                           Clock,
   input  logic                           nReset,
   input  logic                           nClear,
   input  logic                           Enable,
   input  logic                           Error_previous_ga,
   input  logic                           Init,
   input  logic [NUM_STATES-1:0][K-1:0]   alpha_in,
   input  logic signed [M:0]              ba1ba3,
   input  logic signed [N-1:0]            ba2,
   input  logic signed [M:0]              ba1ba2ba3,
   output logic [NUM_STATES-1:0][K-1:0]   alpha_out,
   output logic                           Valid_out,
   output logic                           Error_out,
   output logic [$clog2(I_MAX+1)-1:0]     Iter,
   output logic                           Done
);

   localparam int IW = $clog2(I_MAX + 1);
   localparam logic [NUM_STATES-1:0][31:0] INIT32 = alpha_init(K);

   logic signed [K-1:0]           w_src      [NUM_STATES];
   logic signed [K:0]             w_gam      [4];
   logic signed [K-1:0]           w_br_alpha [NUM_STATES][2];
   logic signed [K:0]             w_br_gamma [NUM_STATES][2];
   logic signed [K:0]             w_metric   [NUM_STATES];
   logic signed [K+1:0]           w_diff     [NUM_STATES];
   logic [NUM_STATES-1:0][K-1:0]  w_norm;
   logic                          w_cap;

   logic [NUM_STATES-1:0][K-1:0]  r_alpha;
   logic                          r_valid;
   logic                          r_err;
   logic [IW-1:0]                 r_iter;

   assign w_cap = Enable && !Error_previous_ga;

   always_comb begin
      for (int s = 0; s < NUM_STATES; s++)
         w_src[s] = Init ? K'(INIT32[s]) : alpha_in[s];
   end

   // Branch metrics indexed by {b1,b2}
   always_comb begin
      w_gam[0] = '0;
      w_gam[1] = (K+1)'(ba2);
      w_gam[2] = (K+1)'(ba1ba3);
      w_gam[3] = (K+1)'(ba1ba2ba3);
   end

   // Scatter each (state, b1) transition onto its next state's ACS input
   always_comb begin
      for (int n = 0; n < NUM_STATES; n++) begin
         for (int b = 0; b < 2; b++) begin
            w_br_alpha[n][b] = '0;
            w_br_gamma[n][b] = '0;
         end
      end
      for (int s = 0; s < NUM_STATES; s++) begin
         for (int b = 0; b < 2; b++) begin
            w_br_alpha[NEXT_STATE[s][b]][b] = w_src[s];
            w_br_gamma[NEXT_STATE[s][b]][b] = w_gam[{1'(b), PARITY[s][b]}];
         end
      end
   end

   for (genvar g = 0; g < NUM_STATES; g++) begin : g_acs
      acs_unit #(.K(K)) u_acs (
         .i_alpha0 (w_br_alpha[g][0]),
         .i_gamma0 (w_br_gamma[g][0]),
         .i_alpha1 (w_br_alpha[g][1]),
         .i_gamma1 (w_br_gamma[g][1]),
         .o_metric (w_metric[g])
      );
   end

   always_comb begin
      for (int n = 0; n < NUM_STATES; n++) begin
         w_diff[n] = (K+2)'(w_metric[n]) - (K+2)'(w_metric[0]);
         w_norm[n] = K'(saturate(32'(w_diff[n]), K));
      end
   end

   always_ff @(posedge Clock or negedge nReset or negedge nClear) begin
      if (!nReset || !nClear) begin
         r_alpha <= '0;
         r_valid <= 1'b0;
         r_err   <= 1'b0;
         r_iter  <= '0;
      end else begin
         r_err   <= Error_previous_ga;
         r_valid <= w_cap;
         if (w_cap) begin
            r_alpha <= w_norm;
            if (r_iter != IW'(I_MAX)) r_iter <= r_iter + 1'b1;
         end
      end
   end

   assign alpha_out = r_alpha;
   assign Valid_out = r_valid;
   assign Error_out = r_err;
   assign Iter      = r_iter;
   assign Done      = (r_iter == IW'(I_MAX));

endmodule

// File: tb/tb_alpha_pipe_razor1.sv
// Bench for alpha_pipe_razor1: trellis-equation model checked every cycle,
// plus hand-computed directed expectations.
module tb_alpha_pipe_razor1;

   localparam int N = 5, M = 6, K = 8, I_MAX = 8;
   localparam int IW = $clog2(I_MAX + 1);

   logic                 Clock = 1'b0;
   logic                 nReset = 1'b0, nClear = 1'b1;
   logic                 Enable = 1'b0, Error_previous_ga = 1'b0, Init = 1'b0;
   logic [7:0][K-1:0]    alpha_in = '0;
   logic signed [M:0]    ba1ba3 = '0, ba1ba2ba3 = '0;
   logic signed [N-1:0]  ba2 = '0;
   logic [7:0][K-1:0]    alpha_out;
   logic                 Valid_out, Error_out, Done;
   logic [IW-1:0]        Iter;

   int n_pass = 0, n_total = 0;
   bit chk_en = 1'b0;

   alpha_pipe_razor1 #(.N(N), .M(M), .K(K), .I_MAX(I_MAX)) dut (
      .Clock(Clock), .nReset(nReset), .nClear(nClear), .Enable(Enable),
      .Error_previous_ga(Error_previous_ga), .Init(Init), .alpha_in(alpha_in),
      .ba1ba3(ba1ba3), .ba2(ba2), .ba1ba2ba3(ba1ba2ba3),
      .alpha_out(alpha_out), .Valid_out(Valid_out), .Error_out(Error_out),
      .Iter(Iter), .Done(Done)
   );

   always #5 Clock = ~Clock;

   task automatic check(input string name, input int got, input int exp);
      n_total++;
      if (got == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", name, got, exp);
   endtask

   // Model: walk every (state, b1) transition straight from the encoder equations
   function automatic logic [7:0][31:0] model_acs();
      int src[8], best[8];
      int r1, r2, r3, f, b2, nx, g, c, d;
      int hi, lo;
      logic [7:0][31:0] res;
      hi = (1 << (K - 1)) - 1;
      lo = -(1 << (K - 1));
      for (int s = 0; s < 8; s++)
         src[s] = Init ? ((s == 0) ? 0 : -(1 << (K - 2))) : int'($signed(alpha_in[s]));
      for (int b1 = 0; b1 < 2; b1++) begin
         for (int s = 0; s < 8; s++) begin
            r1 = (s >> 2) & 1; r2 = (s >> 1) & 1; r3 = s & 1;
            f  = b1 ^ r2 ^ r3;
            b2 = f ^ r1 ^ r3;
            nx = 4 * f + 2 * r1 + r2;
            if (b1 == 0) g = b2 ? int'(ba2) : 0;
            else         g = b2 ? int'(ba1ba2ba3) : int'(ba1ba3);
            c = src[s] + g;
            if (b1 == 0) best[nx] = c;
            else if (c > best[nx]) best[nx] = c;
         end
      end
      for (int n = 0; n < 8; n++) begin
         d = best[n] - best[0];
         if (d > hi) d = hi;
         else if (d < lo) d = lo;
         res[n] = d;
      end
      return res;
   endfunction

   logic [7:0][31:0] m_alpha = '0;
   int               m_iter  = 0;
   logic             m_valid = 1'b0, m_err = 1'b0;

   always @(posedge Clock or negedge nReset or negedge nClear) begin
      if (!nReset || !nClear) begin
         m_alpha <= '0; m_iter <= 0; m_valid <= 1'b0; m_err <= 1'b0;
      end else begin
         m_err   <= Error_previous_ga;
         m_valid <= Enable && !Error_previous_ga;
         if (Enable && !Error_previous_ga) begin
            m_alpha <= model_acs();
            m_iter  <= (m_iter < I_MAX) ? m_iter + 1 : I_MAX;
         end
      end
   end

   always @(negedge Clock) begin
      if (chk_en) begin
         for (int i = 0; i < 8; i++)
            check("model_alpha_out", int'($signed(alpha_out[i])), int'($signed(m_alpha[i])));
         check("model_Valid_out", Valid_out, m_valid);
         check("model_Error_out", Error_out, m_err);
         check("model_Iter", Iter, m_iter);
         check("model_Done", Done, m_iter == I_MAX);
      end
   end

   task automatic step();
      @(posedge Clock);
      #1;
   endtask

   function automatic int a_out(input int i);
      return int'($signed(alpha_out[i]));
   endfunction

   task automatic check_zero(input string tag);
      for (int i = 0; i < 8; i++) check({tag, "_alpha"}, a_out(i), 0);
      check({tag, "_valid"}, Valid_out, 0);
      check({tag, "_iter"}, Iter, 0);
      check({tag, "_done"}, Done, 0);
      check({tag, "_err"}, Error_out, 0);
   endtask

   initial begin
      int v;
      // Reset, then release with Enable low
      repeat (2) step();
      check_zero("reset");
      nReset = 1'b1;
      step();
      check_zero("idle");
      chk_en = 1'b1;

      // Init start vector
      Init = 1'b1; ba1ba3 = 7'sd4; ba2 = 5'sd2; ba1ba2ba3 = 7'sd5; Enable = 1'b1;
      step();
      check("init_a0", a_out(0), 0);
      check("init_a4", a_out(4), 5);
      for (int i = 1; i < 8; i++) begin
         if (i != 4) check("init_range", (a_out(i) >= -64 && a_out(i) <= -59), 1);
      end
      check("init_valid", Valid_out, 1);
      check("init_iter", Iter, 1);
      Enable = 1'b0; Init = 1'b0;
      step();
      check("hold_valid", Valid_out, 0);
      check("hold_a4", a_out(4), 5);

      // Tied branches into next state 0
      for (int i = 0; i < 8; i++) alpha_in[i] = K'(10 * i);
      ba1ba3 = -7'sd3; ba2 = 5'sd5; ba1ba2ba3 = -7'sd10; Enable = 1'b1;
      step();
      check("tie_a0", a_out(0), 0);
      check("tie_a1", a_out(1), 35);
      check("tie_a4", a_out(4), 10);
      check("tie_iter", Iter, 2);

      // Razor error for two cycles
      Error_previous_ga = 1'b1; ba2 = 5'sd0;
      for (int c = 0; c < 2; c++) begin
         step();
         check("err_out", Error_out, 1);
         check("err_valid", Valid_out, 0);
         check("err_hold_a1", a_out(1), 35);
      end
      Error_previous_ga = 1'b0; Enable = 1'b0;
      step();
      check("err_clear", Error_out, 0);
      check("err_iter", Iter, 2);

      // Positive saturation
      for (int i = 0; i < 8; i++) alpha_in[i] = (i < 2) ? K'(-128) : K'(127);
      ba1ba3 = 7'sd63; ba2 = 5'sd15; ba1ba2ba3 = 7'sd63; Enable = 1'b1;
      step();
      check("satp_a0", a_out(0), 0);
      check("satp_a1", a_out(1), 127);
      check("satp_a4", a_out(4), 0);
      // Negative saturation
      for (int i = 0; i < 8; i++) alpha_in[i] = (i < 2) ? K'(127) : K'(-128);
      step();
      check("satn_a0", a_out(0), 0);
      check("satn_a2", a_out(2), -128);

      // Random vectors against the model, some with forced ties
      for (int t = 0; t < 1000; t++) begin
         Enable            = ($urandom_range(0, 7) != 0);
         Error_previous_ga = ($urandom_range(0, 7) == 0);
         Init              = ($urandom_range(0, 9) == 0);
         if (t % 4 == 0) begin
            for (int i = 0; i < 8; i++) alpha_in[i] = K'(10 * i);
            ba1ba3 = -7'sd3; ba2 = N'($urandom); ba1ba2ba3 = -7'sd10;
         end else begin
            for (int i = 0; i < 8; i++) alpha_in[i] = K'($urandom);
            ba1ba3 = (M+1)'($urandom); ba2 = N'($urandom); ba1ba2ba3 = (M+1)'($urandom);
         end
         step();
      end

      // Clear, then I_MAX+2 captures
      Enable = 1'b0; Error_previous_ga = 1'b0; Init = 1'b0;
      nClear = 1'b0;
      #1;
      check_zero("clr1");
      nClear = 1'b1;
      Enable = 1'b1; ba1ba3 = 7'sd1; ba2 = 5'sd2; ba1ba2ba3 = 7'sd3;
      for (int i = 1; i <= I_MAX + 2; i++) begin
         alpha_in[0] = K'(i);
         alpha_in[5] = K'(3 * i);
         step();
         v = (i < I_MAX) ? i : I_MAX;
         check("cnt_iter", Iter, v);
         check("cnt_done", Done, i >= I_MAX);
      end
      // Asynchronous clear mid-cycle while Enable is still high
      #2;
      nClear = 1'b0;
      #1;
      check_zero("clr2");
      step();
      check_zero("clr2_hold");
      nClear = 1'b1; Enable = 1'b0;
      repeat (2) step();
      check("post_iter", Iter, 0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
